sb_rx_rdi_msg_scheduler: RTL and testbench

- Sequences RDI sideband message exchanges on top of the RX RDI decoder output, which supplies valid, 2-bit msg code, 4-bit subcode and 2-bit info.
- Runs two channels:
  - Local channel: a locally issued Req, followed by waiting for the matching remote Resp with a timeout.
  - Remote channel: an incoming Req is forwarded to the RDI state machine; its ack is turned into an outgoing Resp.
- Both channels share one TX sideband encoder port through a round-robin arbiter with a registered output slot.

---
 rtl/sb_rx_rdi_msg_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_sb_rx_rdi_msg_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_rx_rdi_msg_scheduler.sv
// Sideband RDI message scheduler: a local Req/Resp channel with timeout and a remote
// Req -> RDI SM -> Resp channel, both sharing one registered TX slot via round-robin.
module sb_rx_rdi_msg_scheduler #(
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rdi_msg_valid,
    input  logic [1:0] i_rdi_msg_code,
    input  logic [3:0] i_rdi_msg_sub_code,
    input  logic [1:0] i_rdi_msg_info,
    input  logic       i_lcl_req_valid,
    input  logic [3:0] i_lcl_req_sub_code,
    output logic       o_lcl_req_ready,
    output logic       o_lcl_rsp_valid,
    output logic [1:0] o_lcl_rsp_info,
    output logic       o_timeout,
    output logic       o_rmt_req_valid,
    output logic [3:0] o_rmt_req_sub_code,
    input  logic       i_rmt_req_ack,
    input  logic [1:0] i_rmt_rsp_info,
    output logic       o_tx_valid,
    output logic [1:0] o_tx_msg_code,
    output logic [3:0] o_tx_sub_code,
    output logic [1:0] o_tx_info,
    input  logic       i_tx_ready,
    output logic       o_err_unexp,
    output logic       o_err_ovf
);

    // state    | meaning
    // L_IDLE   | local channel free, accepting a request
    // L_SEND   | local Req waiting for the TX slot
    // L_WAIT   | Req sent, waiting for matching Resp or timeout
    // R_IDLE   | remote channel free
    // R_NOTIFY | remote Req presented to the RDI SM, waiting for ack
    // R_SEND   | Resp waiting for the TX slot
    localparam logic [1:0] L_IDLE   = 2'd0;
    localparam logic [1:0] L_SEND   = 2'd1;
    localparam logic [1:0] L_WAIT   = 2'd2;
    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_NOTIFY = 2'd1;
    localparam logic [1:0] R_SEND   = 2'd2;

    localparam logic [1:0] C_REQ = 2'd1;
    localparam logic [1:0] C_RSP = 2'd2;
    localparam logic [1:0] C_RSV = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       lcl_st_q, lcl_st_d;
    logic [3:0]       lcl_sub_q, lcl_sub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lcl_rsp_valid_q, lcl_rsp_valid_d;
    logic [1:0]       lcl_rsp_info_q, lcl_rsp_info_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       rmt_st_q, rmt_st_d;
    logic [3:0]       rmt_sub_q, rmt_sub_d;
    logic [1:0]       rmt_info_q, rmt_info_d;
    logic             tx_valid_q, tx_valid_d;
    logic [1:0]       tx_code_q, tx_code_d;
    logic [3:0]       tx_sub_q, tx_sub_d;
    logic [1:0]       tx_info_q, tx_info_d;
    logic             rr_q, rr_d;
    logic             err_unexp_q, err_unexp_d;
    logic             err_ovf_q, err_ovf_d;

    logic lcl_pend, rmt_pend, load, grant_lcl, rsp_match, is_req;

    always_comb begin
        lcl_pend  = (lcl_st_q == L_SEND);
        rmt_pend  = (rmt_st_q == R_SEND);
        load      = (!tx_valid_q || i_tx_ready) && (lcl_pend || rmt_pend);
        // rr_q == 0 favours the local channel on contention
        grant_lcl = lcl_pend && (!rmt_pend || !rr_q);
        is_req    = i_rdi_msg_valid && (i_rdi_msg_code == C_REQ);
        rsp_match = i_rdi_msg_valid && (i_rdi_msg_code == C_RSP) &&
                    (lcl_st_q == L_WAIT) && (i_rdi_msg_sub_code == lcl_sub_q);

        lcl_st_d        = lcl_st_q;
        lcl_sub_d       = lcl_sub_q;
        cnt_d           = cnt_q;
        lcl_rsp_valid_d = 1'b0;
        lcl_rsp_info_d  = lcl_rsp_info_q;
        timeout_d       = 1'b0;
        rmt_st_d        = rmt_st_q;
        rmt_sub_d       = rmt_sub_q;
        rmt_info_d      = rmt_info_q;
        tx_valid_d      = tx_valid_q && !i_tx_ready;
        tx_code_d       = tx_code_q;
        tx_sub_d        = tx_sub_q;
        tx_info_d       = tx_info_q;
        rr_d            = rr_q;
        err_unexp_d     = i_rdi_msg_valid &&
                          (i_rdi_msg_code == C_RSV || (i_rdi_msg_code == C_RSP && !rsp_match));
        err_ovf_d       = is_req && (rmt_st_q != R_IDLE);

        case (lcl_st_q)
            L_IDLE: begin
                if (i_lcl_req_valid) begin
                    lcl_sub_d = i_lcl_req_sub_code;
                    lcl_st_d  = L_SEND;
                end
            end
            L_SEND: begin
                if (load && grant_lcl) begin
                    cnt_d    = '0;
                    lcl_st_d = L_WAIT;
                end
            end
            L_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (rsp_match) begin
                    lcl_rsp_valid_d = 1'b1;
                    lcl_rsp_info_d  = i_rdi_msg_info;
                    lcl_st_d        = L_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    lcl_st_d  = L_IDLE;
                end
            end
            default: lcl_st_d = L_IDLE;
        endcase

        case (rmt_st_q)
            R_IDLE: begin
                if (is_req) begin
                    rmt_sub_d = i_rdi_msg_sub_code;
                    rmt_st_d  = R_NOTIFY;
                end
            end
            R_NOTIFY: begin
                if (i_rmt_req_ack) begin
                    rmt_info_d = i_rmt_rsp_info;
                    rmt_st_d   = R_SEND;
                end
            end
            R_SEND: begin
                if (load && !grant_lcl) rmt_st_d = R_IDLE;
            end
            default: rmt_st_d = R_IDLE;
        endcase

        if (load) begin
            tx_valid_d = 1'b1;
            if (grant_lcl) begin
                tx_code_d = C_REQ;
                tx_sub_d  = lcl_sub_q;
                tx_info_d = 2'b00;
            end else begin
                tx_code_d = C_RSP;
                tx_sub_d  = rmt_sub_q;
                tx_info_d = rmt_info_q & 2'b01;
            end
            if (lcl_pend && rmt_pend) rr_d = grant_lcl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lcl_st_q        <= L_IDLE;
            lcl_sub_q       <= '0;
            cnt_q           <= '0;
            lcl_rsp_valid_q <= 1'b0;
            lcl_rsp_info_q  <= '0;
            timeout_q       <= 1'b0;
            rmt_st_q        <= R_IDLE;
            rmt_sub_q       <= '0;
            rmt_info_q      <= '0;
            tx_valid_q      <= 1'b0;
            tx_code_q       <= '0;
            tx_sub_q        <= '0;
            tx_info_q       <= '0;
            rr_q            <= 1'b0;
            err_unexp_q     <= 1'b0;
            err_ovf_q       <= 1'b0;
        end else begin
            lcl_st_q        <= lcl_st_d;
            lcl_sub_q       <= lcl_sub_d;
            cnt_q           <= cnt_d;
            lcl_rsp_valid_q <= lcl_rsp_valid_d;
            lcl_rsp_info_q  <= lcl_rsp_info_d;
            timeout_q       <= timeout_d;
            rmt_st_q        <= rmt_st_d;
            rmt_sub_q       <= rmt_sub_d;
            rmt_info_q      <= rmt_info_d;
            tx_valid_q      <= tx_valid_d;
            tx_code_q       <= tx_code_d;
            tx_sub_q        <= tx_sub_d;
            tx_info_q       <= tx_info_d;
            rr_q            <= rr_d;
            err_unexp_q     <= err_unexp_d;
            err_ovf_q       <= err_ovf_d;
        end
    end

    assign o_lcl_req_ready    = (lcl_st_q == L_IDLE);
    assign o_lcl_rsp_valid    = lcl_rsp_valid_q;
    assign o_lcl_rsp_info     = lcl_rsp_info_q;
    assign o_timeout          = timeout_q;
    assign o_rmt_req_valid    = (rmt_st_q == R_NOTIFY);
    assign o_rmt_req_sub_code = rmt_sub_q;
    assign o_tx_valid         = tx_valid_q;
    assign o_tx_msg_code      = tx_code_q;
    assign o_tx_sub_code      = tx_sub_q;
    assign o_tx_info          = tx_info_q;
    assign o_err_unexp        = err_unexp_q;
    assign o_err_ovf          = err_ovf_q;

endmodule

// File: tb/tb_sb_rx_rdi_msg_scheduler.sv
// Directed bench for sb_rx_rdi_msg_scheduler with a 16-cycle timeout.
module tb_sb_rx_rdi_msg_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rdi_valid;
    logic [1:0] rdi_code;
    logic [3:0] rdi_sub;
    logic [1:0] rdi_info;
    logic       lcl_req_valid;
    logic [3:0] lcl_req_sub;
    logic       lcl_req_ready;
    logic       lcl_rsp_valid;
    logic [1:0] lcl_rsp_info;
    logic       timeout;
    logic       rmt_req_valid;
    logic [3:0] rmt_req_sub;
    logic       rmt_req_ack;
    logic [1:0] rmt_rsp_info;
    logic       tx_valid;
    logic [1:0] tx_code;
    logic [3:0] tx_sub;
    logic [1:0] tx_info;
    logic       tx_ready;
    logic       err_unexp;
    logic       err_ovf;

    int checks = 0;
    int errors = 0;
    int to_seen;

    always #5 clk = ~clk;

    sb_rx_rdi_msg_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_rdi_msg_valid    (rdi_valid),
        .i_rdi_msg_code     (rdi_code),
        .i_rdi_msg_sub_code (rdi_sub),
        .i_rdi_msg_info     (rdi_info),
        .i_lcl_req_valid    (lcl_req_valid),
        .i_lcl_req_sub_code (lcl_req_sub),
        .o_lcl_req_ready    (lcl_req_ready),
        .o_lcl_rsp_valid    (lcl_rsp_valid),
        .o_lcl_rsp_info     (lcl_rsp_info),
        .o_timeout          (timeout),
        .o_rmt_req_valid    (rmt_req_valid),
        .o_rmt_req_sub_code (rmt_req_sub),
        .i_rmt_req_ack      (rmt_req_ack),
        .i_rmt_rsp_info     (rmt_rsp_info),
        .o_tx_valid         (tx_valid),
        .o_tx_msg_code      (tx_code),
        .o_tx_sub_code      (tx_sub),
        .o_tx_info          (tx_info),
        .i_tx_ready         (tx_ready),
        .o_err_unexp        (err_unexp),
        .o_err_ovf          (err_ovf)
    );

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rdi(input logic v, input logic [1:0] c, input logic [3:0] s, input logic [1:0] i);
        rdi_valid = v;
        rdi_code  = c;
        rdi_sub   = s;
        rdi_info  = i;
    endtask

    task automatic check_slot(input string tag, input logic [1:0] c, input logic [3:0] s, input logic [1:0] i);
        check_eq({tag, "_valid"}, 8'(tx_valid), 8'd1);
        check_eq({tag, "_code"}, 8'(tx_code), 8'(c));
        check_eq({tag, "_sub"}, 8'(tx_sub), 8'(s));
        check_eq({tag, "_info"}, 8'(tx_info), 8'(i));
    endtask

    // Issue a local request and advance to the edge where it loads into the empty slot.
    task automatic lcl_issue(input logic [3:0] s);
        lcl_req_valid = 1'b1;
        lcl_req_sub   = s;
        tick();
        check_eq("lcl_busy", 8'(lcl_req_ready), 8'd0);
        lcl_req_valid = 1'b0;
        tick();
        check_slot("lcl_load", 2'd1, s, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_rdi(1'b0, 2'd0, 4'd0, 2'd0);
        lcl_req_valid = 1'b0;
        lcl_req_sub   = 4'd0;
        rmt_req_ack   = 1'b0;
        rmt_rsp_info  = 2'd0;
        tx_ready      = 1'b1;

        // reset while inputs toggle
        lcl_req_valid = 1'b1;
        set_rdi(1'b1, 2'd1, 4'hA, 2'd3);
        tick();
        lcl_req_valid = 1'b0;
        set_rdi(1'b1, 2'd3, 4'h5, 2'd1);
        rmt_req_ack = 1'b1;
        tick();
        check_eq("rst_tx_valid", 8'(tx_valid), 8'd0);
        check_eq("rst_rsp_valid", 8'(lcl_rsp_valid), 8'd0);
        check_eq("rst_timeout", 8'(timeout), 8'd0);
        check_eq("rst_rmt_valid", 8'(rmt_req_valid), 8'd0);
        check_eq("rst_errs", {6'd0, err_unexp, err_ovf}, 8'd0);
        set_rdi(1'b0, 2'd0, 4'd0, 2'd0);
        rmt_req_ack = 1'b0;
        rst_n = 1'b1;
        tick();
        check_eq("rst_ready", 8'(lcl_req_ready), 8'd1);
        check_eq("rst_tx_code", 8'(tx_code), 8'd0);

        // basic local exchange
        lcl_issue(4'h5);
        tick();
        check_eq("slot_drain", 8'(tx_valid), 8'd0);
        set_rdi(1'b1, 2'd2, 4'h5, 2'b01);
        tick();
        set_rdi(1'b0, 2'd0, 4'd0, 2'd0);
        check_eq("rsp_valid", 8'(lcl_rsp_valid), 8'd1);
        check_eq("rsp_info", 8'(lcl_rsp_info), 8'd1);
        check_eq("rsp_ready", 8'(lcl_req_ready), 8'd1);
        check_eq("rsp_no_unexp", 8'(err_unexp), 8'd0);
        tick();
        check_eq("rsp_pulse_end", 8'(lcl_rsp_valid), 8'd0);

        // timeout: pulse on the 16th edge after the load edge
        lcl_issue(4'hA);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check_eq("to_early", 8'(timeout), 8'd0);
        end
        tick();
        check_eq("to_pulse", 8'(timeout), 8'd1);
        check_eq("to_no_rsp", 8'(lcl_rsp_valid), 8'd0);
        tick();
        check_eq("to_pulse_end", 8'(timeout), 8'd0);
        check_eq("to_ready", 8'(lcl_req_ready), 8'd1);

        // match on the expiry cycle wins
        lcl_issue(4'hC);
        repeat (15) tick();
        set_rdi(1'b1, 2'd2, 4'hC, 2'b10);
        tick();
        set_rdi(1'b0, 2'd0, 4'd0, 2'd0);
        check_eq("exp_rsp_valid", 8'(lcl_rsp_valid), 8'd1);
        check_eq("exp_rsp_info", 8'(lcl_rsp_info), 8'd2);
        check_eq("exp_no_to", 8'(timeout), 8'd0);
        tick();
        check_eq("exp_no_to_late", 8'(timeout), 8'd0);

        // remote channel with overflow
        set_rdi(1'b1, 2'd1, 4'h3, 2'd0);
        tick();
        check_eq("rmt_valid", 8'(rmt_req_valid), 8'd1);
        check_eq("rmt_sub", 8'(rmt_req_sub), 8'd3);
        set_rdi(1'b1, 2'd1, 4'h7, 2'd0);
        tick();
        set_rdi(1'b0, 2'd0, 4'd0, 2'd0);
        check_eq("ovf_pulse", 8'(err_ovf), 8'd1);
        check_eq("ovf_keep_sub", 8'(rmt_req_sub), 8'd3);
        rmt_req_ack  = 1'b1;
        rmt_rsp_info = 2'b11;
        tick();
        rmt_req_ack  = 1'b0;
        rmt_rsp_info = 2'b00;
        check_eq("ovf_pulse_end", 8'(err_ovf), 8'd0);
        check_eq("rmt_valid_drop", 8'(rmt_req_valid), 8'd0);
        tick();
        check_slot("rmt_rsp", 2'd2, 4'h3, 2'b01);
        tick();
        check_eq("rmt_drain", 8'(tx_valid), 8'd0);

        // unexpected responses and reserved code
        set_rdi(1'b1, 2'd2, 4'h1, 2'd1);
        tick();
        check_eq("unexp_idle", 8'(err_unexp), 8'd1);
        check_eq("unexp_idle_rsp", 8'(lcl_rsp_valid), 8'd0);
        set_rdi(1'b1, 2'd3, 4'h2, 2'd0);
        tick();
        check_eq("unexp_rsv", 8'(err_unexp), 8'd1);
        check_eq("unexp_rsv_rmt", 8'(rmt_req_valid), 8'd0);
        set_rdi(1'b0, 2'd0, 4'd0, 2'd0);
        tick();
        check_eq("unexp_end", 8'(err_unexp), 8'd0);
        check_eq("unexp_ready", 8'(lcl_req_ready), 8'd1);

        // contention: local first (rr at reset), slot held while stalled
        tx_ready = 1'b0;
        set_rdi(1'b1, 2'd1, 4'h6, 2'd0);
        tick();
        set_rdi(1'b0, 2'd0, 4'd0, 2'd0);
        rmt_req_ack   = 1'b1;
        rmt_rsp_info  = 2'b01;
        lcl_req_valid = 1'b1;
        lcl_req_sub   = 4'h9;
        tick();
        rmt_req_ack   = 1'b0;
        lcl_req_valid = 1'b0;
        check_eq("cont1_empty", 8'(tx_valid), 8'd0);
        tick();
        check_slot("cont1_first", 2'd1, 4'h9, 2'd0);
        repeat (5) begin
            tick();
            check_slot("cont1_hold", 2'd1, 4'h9, 2'd0);
        end
        tx_ready = 1'b1;
        tick();
        check_slot("cont1_second", 2'd2, 4'h6, 2'b01);
        tick();
        check_eq("cont1_drain", 8'(tx_valid), 8'd0);
        set_rdi(1'b1, 2'd2, 4'h9, 2'b10);
        tick();
        set_rdi(1'b0, 2'd0, 4'd0, 2'd0);
        check_eq("cont1_rsp", 8'(lcl_rsp_valid), 8'd1);

        // second contention: pointer now favours remote
        tx_ready = 1'b0;
        set_rdi(1'b1, 2'd1, 4'h2, 2'd0);
        tick();
        set_rdi(1'b0, 2'd0, 4'd0, 2'd0);
        rmt_req_ack   = 1'b1;
        rmt_rsp_info  = 2'b10;
        lcl_req_valid = 1'b1;
        lcl_req_sub   = 4'h4;
        tick();
        rmt_req_ack   = 1'b0;
        lcl_req_valid = 1'b0;
        tick();
        check_slot("cont2_first", 2'd2, 4'h2, 2'b00);
        tx_ready = 1'b1;
        tick();
        check_slot("cont2_second", 2'd1, 4'h4, 2'd0);
        tick();
        check_eq("cont2_drain", 8'(tx_valid), 8'd0);

        // wrong subcode while waiting
        set_rdi(1'b1, 2'd2, 4'h8, 2'd1);
        tick();
        set_rdi(1'b0, 2'd0, 4'd0, 2'd0);
        check_eq("wrong_sub_unexp", 8'(err_unexp), 8'd1);
        check_eq("wrong_sub_rsp", 8'(lcl_rsp_valid), 8'd0);
        check_eq("wrong_sub_busy", 8'(lcl_req_ready), 8'd0);

        // reset in L_WAIT abandons silently
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        to_seen = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (timeout || err_unexp || err_ovf) to_seen++;
        end
        check_eq("rst_wait_no_pulse", 8'(to_seen), 8'd0);
        check_eq("rst_wait_ready", 8'(lcl_req_ready), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
